// File: rtl/axi_llc_pkg.sv
// rtl/axi_llc_pkg.sv - shared LLC types for the R-channel merge stage
package axi_llc_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOCK_CACHE = 2'd1,
    LOCK_BYP   = 2'd2
  } r_merge_state_e;

  // Default slave-port R beat layout; integrations override r_chan_t with their own struct
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } llc_r_chan_t;

endpackage

// File: rtl/spill_register.sv
// rtl/spill_register.sv - two-entry spill register, full throughput, registered valid/data
module spill_register #(
  parameter type T      = logic,
  parameter bit  Bypass = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  if (Bypass) begin : g_bypass
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
  end else begin : g_spill
    T     a_data_q, b_data_q;
    logic a_full_q, b_full_q;
    logic a_fill, a_drain, b_fill, b_drain;

    // a is the primary slot; b only catches a's beat when the output stalls
    assign a_fill  = valid_i & ready_o;
    assign a_drain = a_full_q & ~b_full_q;
    assign b_fill  = a_drain & ~ready_i;
    assign b_drain = b_full_q & ready_i;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        a_full_q <= 1'b0;
        b_full_q <= 1'b0;
      end else begin
        a_full_q <= a_fill | (a_full_q & ~a_drain);
        b_full_q <= b_fill | (b_full_q & ~b_drain);
      end
    end

    always_ff @(posedge clk_i) begin
      if (a_fill) a_data_q <= data_i;
      if (b_fill) b_data_q <= a_data_q;
    end

    assign ready_o = ~a_full_q | ~b_full_q;
    assign valid_o = a_full_q | b_full_q;
    assign data_o  = b_full_q ? b_data_q : a_data_q;
  end

endmodule

// File: rtl/axi_llc_r_merge.sv
// rtl/axi_llc_r_merge.sv - burst-atomic round-robin merge of cache and bypass R beats
module axi_llc_r_merge
  import axi_llc_pkg::*;
#(
  parameter type r_chan_t = llc_r_chan_t,
  parameter bit  SpillReg = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  r_chan_t    cache_r_i,
  input  logic       cache_r_valid_i,
  output logic       cache_r_ready_o,
  input  r_chan_t    byp_r_i,
  input  logic       byp_r_valid_i,
  output logic       byp_r_ready_o,
  output r_chan_t    r_chan_slv_o,
  output logic       r_chan_valid_o,
  input  logic       r_chan_ready_i,
  output logic [1:0] lock_o
);

  r_merge_state_e state_q, state_d;
  logic           prio_q, prio_d;
  logic [1:0]     lock_q;
  logic           sel_cache, sel_byp;
  logic           out_valid, out_ready, acc;
  r_chan_t        out_data;

  // Grant: free choice only in IDLE; once locked the burst owner keeps the output
  always_comb begin
    sel_cache = 1'b0;
    sel_byp   = 1'b0;
    case (state_q)
      IDLE: begin
        sel_cache = cache_r_valid_i & (~byp_r_valid_i | ~prio_q);
        sel_byp   = byp_r_valid_i & (~cache_r_valid_i | prio_q);
      end
      LOCK_CACHE: sel_cache = 1'b1;
      LOCK_BYP:   sel_byp   = 1'b1;
      default: ;
    endcase
  end

  assign out_valid       = (sel_cache & cache_r_valid_i) | (sel_byp & byp_r_valid_i);
  assign out_data        = sel_byp ? byp_r_i : cache_r_i;
  assign cache_r_ready_o = sel_cache & out_ready;
  assign byp_r_ready_o   = sel_byp & out_ready;
  assign acc             = out_valid & out_ready;

  // Priority flips only at burst end so both sources alternate whole bursts
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (acc) begin
      if (out_data.last) begin
        state_d = IDLE;
        prio_d  = sel_cache;
      end else if (state_q == IDLE) begin
        state_d = sel_cache ? LOCK_CACHE : LOCK_BYP;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      lock_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      lock_q  <= {state_d == LOCK_BYP, state_d == LOCK_CACHE};
    end
  end

  assign lock_o = lock_q;

  spill_register #(
    .T      (r_chan_t),
    .Bypass (!SpillReg)
  ) i_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (out_valid),
    .ready_o (out_ready),
    .data_i  (out_data),
    .valid_o (r_chan_valid_o),
    .ready_i (r_chan_ready_i),
    .data_o  (r_chan_slv_o)
  );

endmodule

// File: tb/tb_axi_llc_r_merge.sv
// tb/tb_axi_llc_r_merge.sv - directed self-checking bench for axi_llc_r_merge
module tb_axi_llc_r_merge;
  import axi_llc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  llc_r_chan_t cache_r_i, byp_r_i, r_chan_slv_o;
  logic        cache_r_valid_i, cache_r_ready_o;
  logic        byp_r_valid_i, byp_r_ready_o;
  logic        r_chan_valid_o, r_chan_ready_i;
  logic [1:0]  lock_o;

  axi_llc_r_merge dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .cache_r_i       (cache_r_i),
    .cache_r_valid_i (cache_r_valid_i),
    .cache_r_ready_o (cache_r_ready_o),
    .byp_r_i         (byp_r_i),
    .byp_r_valid_i   (byp_r_valid_i),
    .byp_r_ready_o   (byp_r_ready_o),
    .r_chan_slv_o    (r_chan_slv_o),
    .r_chan_valid_o  (r_chan_valid_o),
    .r_chan_ready_i  (r_chan_ready_i),
    .lock_o          (lock_o)
  );

  always #5 clk = ~clk;

  llc_r_chan_t cq[$], bq[$], outq[$];
  int          outc[$];
  int          passed = 0, total = 0, fails = 0;
  int          cyc = 0;
  logic        byp_gap = 1'b0, bp_mode = 1'b0, bp_phase = 1'b1;
  logic        cf, bf, of, prev_stall = 1'b0;
  llc_r_chan_t od, prev_d;
  int          stab_err = 0, stall_cnt = 0, cache_rdy_seen = 0;

  function automatic llc_r_chan_t mk(input logic [3:0] id, input logic [31:0] data, input logic last);
    llc_r_chan_t b;
    b.id = id; b.data = data; b.resp = 2'b00; b.last = last; b.user = 1'b0;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    cache_r_valid_i = (cq.size() > 0);
    cache_r_i       = (cq.size() > 0) ? cq[0] : '0;
    byp_r_valid_i   = (bq.size() > 0) && !byp_gap;
    byp_r_i         = (bq.size() > 0) ? bq[0] : '0;
    r_chan_ready_i  = bp_mode ? bp_phase : 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    cf = cache_r_valid_i & cache_r_ready_o;
    bf = byp_r_valid_i & byp_r_ready_o;
    of = r_chan_valid_o & r_chan_ready_i;
    od = r_chan_slv_o;
    if (bq.size() > 0 && cache_r_ready_o) cache_rdy_seen++;
    if (prev_stall && !(r_chan_valid_o === 1'b1 && r_chan_slv_o === prev_d)) stab_err++;
    prev_stall = r_chan_valid_o & ~r_chan_ready_i;
    if (prev_stall) stall_cnt++;
    prev_d = r_chan_slv_o;
    @(posedge clk);
    #1;
    cyc++;
    if (cf) cq.delete(0);
    if (bf) bq.delete(0);
    if (of) begin
      outq.push_back(od);
      outc.push_back(cyc);
    end
    bp_phase = ~bp_phase;
    drive();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    cq.delete(); bq.delete();
    byp_gap = 1'b0; bp_mode = 1'b0; bp_phase = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    outq.delete(); outc.delete();
    prev_stall = 1'b0; stab_err = 0; stall_cnt = 0; cache_rdy_seen = 0;
    drive();
  endtask

  task automatic drain(input string tag, input int n);
    int b = 0;
    while (outq.size() < n && b < 200) begin
      tick();
      b++;
    end
    chk(tag, outq.size(), n);
  endtask

  initial begin
    int gap_left;
    do_reset();

    // Reset state
    chk("rst_valid", r_chan_valid_o, 1'b0);
    chk("rst_lock", lock_o, 2'b00);
    chk("rst_cache_rdy", cache_r_ready_o, 1'b0);
    chk("rst_prio", dut.prio_q, 1'b0);

    // Single 4-beat cache burst, id 3
    for (int i = 0; i < 4; i++) cq.push_back(mk(4'd3, 32'hC100_0000 + i, i == 3));
    drive();
    #1;
    chk("t1_cache_rdy", cache_r_ready_o, 1'b1);
    chk("t1_byp_rdy", byp_r_ready_o, 1'b0);
    tick();
    chk("t1_lock_b1", lock_o, 2'b01);
    repeat (3) tick();
    chk("t1_lock_b4", lock_o, 2'b00);
    drain("t1_count", 4);
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      chk($sformatf("t1_data%0d", i), outq[i].data, 32'hC100_0000 + i);
      chk($sformatf("t1_last%0d", i), outq[i].last, (i == 3));
      chk($sformatf("t1_id%0d", i), outq[i].id, 4'd3);
    end

    // Simultaneous start: cache 2 beats, bypass 3 beats
    do_reset();
    for (int i = 0; i < 2; i++) cq.push_back(mk(4'd3, 32'hC200_0000 + i, i == 1));
    for (int i = 0; i < 3; i++) bq.push_back(mk(4'd5, 32'hB200_0000 + i, i == 2));
    drive();
    tick();
    tick();
    chk("t2_prio", dut.prio_q, 1'b1);
    drain("t2_count", 5);
    if (outq.size() == 5) begin
      chk("t2_o0", outq[0].data, 32'hC200_0000);
      chk("t2_o1", outq[1].data, 32'hC200_0001);
      chk("t2_o2", outq[2].data, 32'hB200_0000);
      chk("t2_o3", outq[3].data, 32'hB200_0001);
      chk("t2_o4", outq[4].data, 32'hB200_0002);
      chk("t2_nogap", outc[4] - outc[0], 4);
    end

    // No interleave: 8-beat bypass with a 2-cycle bubble after beat 3
    do_reset();
    for (int i = 0; i < 8; i++) bq.push_back(mk(4'd5, 32'hB300_0000 + i, i == 7));
    drive();
    tick();
    cq.push_back(mk(4'd3, 32'hC300_0000, 1'b1));
    drive();
    gap_left = 2;
    for (int b = 0; b < 40 && bq.size() > 0; b++) begin
      tick();
      if (bq.size() == 5 && gap_left > 0) begin
        byp_gap = 1'b1;
        gap_left--;
        chk("t3_gap_lock", lock_o, 2'b10);
      end else begin
        byp_gap = 1'b0;
      end
      drive();
    end
    chk("t3_gaps_done", gap_left, 0);
    chk("t3_cache_rdy", cache_rdy_seen, 0);
    drain("t3_count", 9);
    for (int i = 0; i < 8 && i < outq.size(); i++)
      chk($sformatf("t3_byp%0d", i), outq[i].data, 32'hB300_0000 + i);
    if (outq.size() == 9) chk("t3_cache_last", outq[8].data, 32'hC300_0000);

    // Fairness: 10 single-beat bursts from each source
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cq.push_back(mk(4'd3, 32'hC400_0000 + i, 1'b1));
      bq.push_back(mk(4'd5, 32'hB400_0000 + i, 1'b1));
    end
    drive();
    drain("t4_count", 20);
    if (outq.size() == 20) begin
      for (int i = 0; i < 20; i++)
        chk($sformatf("t4_o%0d", i), outq[i].data,
            ((i % 2 == 0) ? 32'hC400_0000 : 32'hB400_0000) + (i / 2));
      chk("t4_rate", outc[19] - outc[0], 19);
    end

    // Backpressure: downstream ready toggles every cycle
    do_reset();
    bp_mode = 1'b1;
    for (int i = 0; i < 4; i++) cq.push_back(mk(4'd3, 32'hC500_0000 + i, i == 3));
    drive();
    drain("t5_count", 4);
    repeat (4) tick();
    chk("t5_nodup", outq.size(), 4);
    chk("t5_stable", stab_err, 0);
    chk("t5_stalled", stall_cnt > 0, 1'b1);
    for (int i = 0; i < 4 && i < outq.size(); i++)
      chk($sformatf("t5_data%0d", i), outq[i].data, 32'hC500_0000 + i);

    // Reset mid-burst, then a bypass burst is granted at once
    do_reset();
    for (int i = 0; i < 4; i++) cq.push_back(mk(4'd3, 32'hC600_0000 + i, i == 3));
    drive();
    tick();
    tick();
    chk("t6_lock_pre", lock_o, 2'b01);
    chk("t6_valid_pre", r_chan_valid_o, 1'b1);
    cq.delete();
    rst_ni = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    chk("t6_valid_post", r_chan_valid_o, 1'b0);
    chk("t6_lock_post", lock_o, 2'b00);
    outq.delete(); outc.delete(); prev_stall = 1'b0;
    for (int i = 0; i < 2; i++) bq.push_back(mk(4'd5, 32'hB600_0000 + i, i == 1));
    drive();
    tick();
    chk("t6_byp_grant", bf, 1'b1);
    chk("t6_lock_byp", lock_o, 2'b10);
    drain("t6_count", 2);
    if (outq.size() == 2) chk("t6_first", outq[0].data, 32'hB600_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
